// File: rtl/vga_frame_arbiter.sv
// Round-robin arbiter that takes one 8x8 bitmap from either of two requesters and
// commits it to the display register only on a qualifying vblank rising edge.
module vga_frame_arbiter #(
  parameter int DW         = 64,
  parameter int MIN_FRAMES = 1
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          vblank,
  input  logic          req_a_valid,
  input  logic [DW-1:0] req_a_data,
  input  logic          req_b_valid,
  input  logic [DW-1:0] req_b_data,
  output logic          req_a_ready,
  output logic          req_b_ready,
  output logic [DW-1:0] vdata,
  output logic          commit,
  output logic [7:0]    frame_cnt,
  output logic          busy
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] MIN_F = 4'(MIN_FRAMES);

  state_t        state, state_next;
  logic          last_grant;
  logic [DW-1:0] pending;
  logic [3:0]    frames_since;
  logic          vblank_q;
  logic          vblank_edge;
  logic          grant_a, grant_b;
  logic          commit_now;
  logic          handshake;

  // last_grant: 0 = A won most recently, 1 = B; a tie goes to the other one
  always_comb begin
    grant_a = req_a_valid && (!req_b_valid || last_grant);
    grant_b = req_b_valid && (!req_a_valid || !last_grant);
  end

  assign vblank_edge = vblank && !vblank_q;
  assign commit_now  = (state == PEND) && vblank_edge &&
                       (({1'b0, frames_since} + 5'd1) >= {1'b0, MIN_F});
  assign handshake   = req_a_ready || req_b_ready;
  assign busy        = (state == PEND);

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    case (state)
      IDLE: begin
        req_a_ready = grant_a;
        req_b_ready = grant_b;
        if (grant_a || grant_b) state_next = PEND;
      end
      PEND: begin
        if (commit_now) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // vblank_q resets high so a vblank already high at release is not an edge
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vdata        <= '0;
      pending      <= '0;
      commit       <= 1'b0;
      frame_cnt    <= 8'd0;
      last_grant   <= 1'b1;
      frames_since <= MIN_F;
      vblank_q     <= 1'b1;
    end else begin
      vblank_q <= vblank;
      commit   <= commit_now;
      if (handshake) begin
        pending    <= req_a_ready ? req_a_data : req_b_data;
        last_grant <= req_b_ready;
      end
      if (commit_now) begin
        vdata        <= pending;
        frame_cnt    <= frame_cnt + 8'd1;
        frames_since <= 4'd0;
      end else if (vblank_edge && (frames_since < MIN_F)) begin
        frames_since <= frames_since + 4'd1;
      end
    end
  end

endmodule

// File: doc/vga_frame_arbiter.md
VGA_FRAME_ARBITER -- requirements
Module: vga_frame_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 64, which is the frame image width in bits (one bit per pixel of the 8x8 bitmap).
REQ-002 The block SHALL have parameter MIN_FRAMES, default 1, range 1..15, which is the minimum number of vblank rising edges between two commits.
REQ-003 The block SHALL have port dclk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port vblank, input, 1 bit: level, high during vertical blanking, synchronous to dclk.
REQ-006 The block SHALL have ports req_a_valid / req_b_valid, input, 1 bit each: requester A/B offers an image.
REQ-007 The block SHALL have ports req_a_data / req_b_data, input, DW bits each: requester A/B image.
REQ-008 The block SHALL have ports req_a_ready / req_b_ready, output, 1 bit each: image accepted this cycle when valid && ready.
REQ-009 The block SHALL have port vdata, output, DW bits: displayed image, registered.
REQ-010 The block SHALL have port commit, output, 1 bit: one-cycle pulse, registered, when vdata updates.
REQ-011 The block SHALL have port frame_cnt, output, 8 bits: count of commits, registered.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an accepted image awaits commit (state PEND).

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and PEND.
REQ-014 In IDLE, ready SHALL be combinational: req_x_ready = (state==IDLE) && grant_x; at most one ready is high in any cycle.
REQ-015 The grant SHALL follow these rules: only A valid -> A; only B valid -> B; both valid -> the requester not equal to last_grant (round-robin); neither valid -> no grant.
REQ-016 On a handshake in IDLE, the block SHALL latch the granted data into the pending register, set last_grant to the winner, and enter PEND on the next cycle.
REQ-017 In PEND, both ready outputs SHALL be 0; requesters hold valid/data until they are granted.
REQ-018 A vblank edge SHALL be defined as vblank && !vblank_q, where vblank_q is vblank registered by one cycle.
REQ-019 The frames_since counter SHALL be 4 bits and saturate at MIN_FRAMES; it increments on every vblank edge, in any state.
REQ-020 On a commit, frames_since SHALL be cleared to 0; the commit-cycle edge is not counted.
REQ-021 A commit SHALL occur in PEND on a vblank edge cycle when frames_since + 1 >= MIN_FRAMES.
REQ-022 On the clock edge that ends a commit cycle, the block SHALL do all of the following together: vdata <= pending, commit <= 1, frame_cnt <= frame_cnt + 1 (mod 256, wraps 255 -> 0), state <= IDLE.
REQ-023 Commit latency SHALL be: vdata and commit change in the cycle after the vblank edge cycle; commit is high for exactly 1 cycle.
REQ-024 A vblank edge in the same cycle as an IDLE handshake SHALL NOT commit that image; it waits for the next qualifying edge but still counts toward frames_since.
REQ-025 An image SHALL NOT be accepted in the cycle of a commit, because state is PEND in that cycle; the earliest next acceptance is the following cycle.
REQ-026 Pending data SHALL never reach vdata outside the commit cycle, so vdata is stable during active video (tear-free).
REQ-027 busy SHALL equal (state==PEND).

Reset
REQ-028 While clr_n = 0, the block SHALL hold state = IDLE, vdata = 0, pending = 0, commit = 0, frame_cnt = 0, last_grant = B (so A wins the first tie), frames_since = MIN_FRAMES, and vblank_q = 1 (so vblank high at reset release gives no edge).
REQ-029 Reset asserted mid-PEND SHALL discard the pending image, and the requester is not re-granted without a new handshake.

Verification
REQ-030 Scenario: reset, then A valid data=64'hFF00FF00FF00FF00 with vblank=0 -> req_a_ready=1 in the cycle after release, busy=1 next cycle; vblank rises -> vdata=64'hFF00FF00FF00FF00 and commit=1 one cycle later, frame_cnt=1.
REQ-031 Scenario: A and B both valid continuously, MIN_FRAMES=1 -> grants alternate A, B, A, B with one commit per vblank edge, and frame_cnt increments by 1 each frame.
REQ-032 Scenario: handshake in the same cycle as a vblank rising edge -> no commit on that edge, commit on the next edge, vdata unchanged in between.
REQ-033 Scenario: MIN_FRAMES=3 with back-to-back requests -> commits spaced exactly 3 vblank edges apart.
REQ-034 Scenario: clr_n pulsed low while busy=1 -> vdata=0, busy=0, frame_cnt=0, and no commit pulse is produced on the next vblank.
REQ-035 Scenario: 256 commits -> frame_cnt wraps to 0, and commit still pulses.
